// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type and ConfigBits field positions for the parametrised register file
package regfile_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int CFG_AD_REG = 0;
  localparam int CFG_BD_REG = 1;
  localparam int CFG_BYPASS = 2;
  localparam int CFG_SKIP_CLR = 3;
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: post-reset memory clear sweep, drives a zeroing write port while busy
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  UserCLK,
  input  logic                  RESETn,
  input  logic                  skip_clr,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_adr
);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  // State and sweep pointer; the pointer advances only on edges that actually clear an entry
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      clr_ptr <= clr_we ? clr_ptr + 1'b1 : clr_ptr;
    end
  end
  // Leave CLEAR on the edge that writes the last entry, or at once when clearing is skipped
  always_comb begin
    state_d = (state_q == CLEAR && (skip_clr || clr_ptr == '1)) ? READY : state_q;
  end
  // BUSY is a pure decode of the registered state
  always_comb begin
    busy = (state_q == CLEAR);
    clr_we = (state_q == CLEAR) && !skip_clr;
    clr_adr = clr_ptr;
  end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: two-read/one-write register file with optional output registers, bypass and clear sweep
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int NoConfigBits = 4
) (
  input  logic                    UserCLK,
  input  logic                    RESETn,
  input  logic [DATA_WIDTH-1:0]   D,
  input  logic [ADDR_WIDTH-1:0]   W_ADR,
  input  logic                    W_en,
  output logic [DATA_WIDTH-1:0]   AD,
  input  logic [ADDR_WIDTH-1:0]   A_ADR,
  input  logic                    A_en,
  output logic [DATA_WIDTH-1:0]   BD,
  input  logic [ADDR_WIDTH-1:0]   B_ADR,
  input  logic                    B_en,
  output logic                    BUSY,
  input  logic [NoConfigBits-1:0] ConfigBits
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic busy, clr_we, we;
  logic [ADDR_WIDTH-1:0] clr_adr, wadr;
  logic [DATA_WIDTH-1:0] wdata, rd_a, rd_b, ad_reg, bd_reg;

  regfile_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
    .UserCLK (UserCLK),
    .RESETn  (RESETn),
    .skip_clr(ConfigBits[CFG_SKIP_CLR]),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_adr (clr_adr)
  );

  assign BUSY = busy;

  // Write port belongs to the sweep while busy; reads see bypassed data when enabled
  always_comb begin
    we = busy ? clr_we : W_en;
    wadr = busy ? clr_adr : W_ADR;
    wdata = busy ? '0 : D;
    rd_a = (ConfigBits[CFG_BYPASS] && W_en && W_ADR == A_ADR) ? D : mem[A_ADR];
    rd_b = (ConfigBits[CFG_BYPASS] && W_en && W_ADR == B_ADR) ? D : mem[B_ADR];
    AD = busy ? '0 : ConfigBits[CFG_AD_REG] ? ad_reg : rd_a;
    BD = busy ? '0 : ConfigBits[CFG_BD_REG] ? bd_reg : rd_b;
  end

  // Storage array, deliberately without reset; zeroing is done by the sweep
  always_ff @(posedge UserCLK) begin
    if (we) mem[wadr] <= wdata;
  end

  // Output registers sample the raw read data, never AD/BD, so no loop through the output mux
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      ad_reg <= '0;
      bd_reg <= '0;
    end else begin
      ad_reg <= busy ? '0 : A_en ? rd_a : ad_reg;
      bd_reg <= busy ? '0 : B_en ? rd_b : bd_reg;
    end
  end
endmodule
